// File: rtl/simmem_rsp_release_timer_pkg.sv
// Shared constants and slot state encoding for the response release timers.
package simmem_rsp_release_timer_pkg;

    localparam int unsigned DelayW        = 8;
    localparam int unsigned WRspBankCapa  = 16;
    localparam int unsigned RDataBankCapa = 16;

    typedef enum logic [1:0] {
        SLOT_IDLE     = 2'd0,
        SLOT_COUNTING = 2'd1,
        SLOT_ARMED    = 2'd2
    } slot_state_e;

endpackage

// File: rtl/simmem_rsp_release_timer_slot.sv
// One bank slot: loads a delay, counts it down while enabled, then arms the
// release enable until the bank acknowledges the release.
module simmem_rsp_release_timer_slot
    import simmem_rsp_release_timer_pkg::*;
#(
    parameter int unsigned CntW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CntW-1:0] delay,
    input  logic            count_en,
    input  logic            release_pulse,
    output slot_state_e     state,
    output logic            release_en,
    output logic            bad_release
);

    slot_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic            release_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SLOT_IDLE;
            cnt_q        <= '0;
            release_en_q <= 1'b0;
        end else begin
            case (state_q)
                SLOT_IDLE: begin
                    if (load) begin
                        // Delays of 0 and 1 both arm on the next cycle.
                        if (delay <= CntW'(1)) begin
                            state_q      <= SLOT_ARMED;
                            release_en_q <= 1'b1;
                        end else begin
                            state_q <= SLOT_COUNTING;
                            cnt_q   <= delay - CntW'(1);
                        end
                    end
                end
                SLOT_COUNTING: begin
                    if (count_en) begin
                        if (cnt_q == CntW'(1)) begin
                            state_q      <= SLOT_ARMED;
                            cnt_q        <= '0;
                            release_en_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                end
                SLOT_ARMED: begin
                    // First beat frees the slot; the bank tracks burst progress itself.
                    if (release_pulse) begin
                        state_q      <= SLOT_IDLE;
                        release_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= SLOT_IDLE;
                    cnt_q        <= '0;
                    release_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign state       = state_q;
    assign release_en  = release_en_q;
    assign bad_release = release_pulse && (state_q != SLOT_ARMED);

endmodule

// File: rtl/simmem_rsp_release_timer.sv
// Per-bank release timer: decodes delay entries onto slot timers, tracks the
// number of occupied slots and flags releases of slots that were not armed.
module simmem_rsp_release_timer #(
    parameter int unsigned NumSlots = simmem_rsp_release_timer_pkg::WRspBankCapa,
    parameter int unsigned DelayW   = simmem_rsp_release_timer_pkg::DelayW,
    parameter int unsigned IidW     = $clog2(NumSlots)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                entry_valid_i,
    output logic                entry_ready_o,
    input  logic [IidW-1:0]     entry_iid_i,
    input  logic [DelayW-1:0]   entry_delay_i,
    input  logic                count_en_i,
    output logic [NumSlots-1:0] release_en_o,
    input  logic [NumSlots-1:0] released_addr_onehot_i,
    output logic [IidW:0]       num_pending_o,
    output logic                err_o
);
    import simmem_rsp_release_timer_pkg::*;

    slot_state_e         slot_state [NumSlots];
    logic [NumSlots-1:0] idle;
    logic [NumSlots-1:0] armed;
    logic [NumSlots-1:0] load;
    logic [NumSlots-1:0] bad;
    logic [NumSlots-1:0] rel_en;
    logic [NumSlots-1:0] valid_rel;
    logic                accept;
    logic [IidW:0]       rel_cnt;
    logic [IidW:0]       pending_d;
    logic [IidW:0]       pending_q;
    logic                err_q;

    // Ready comes from registered state only, so a slot freed this cycle is
    // not reusable until the next one.
    assign entry_ready_o = idle[entry_iid_i];
    assign accept        = entry_valid_i && entry_ready_o;

    for (genvar i = 0; i < NumSlots; i++) begin : g_slot
        assign load[i] = accept && (entry_iid_i == IidW'(i));

        simmem_rsp_release_timer_slot #(
            .CntW (DelayW)
        ) u_slot (
            .clk           (clk_i),
            .rst           (rst_i),
            .load          (load[i]),
            .delay         (entry_delay_i),
            .count_en      (count_en_i),
            .release_pulse (released_addr_onehot_i[i]),
            .state         (slot_state[i]),
            .release_en    (rel_en[i]),
            .bad_release   (bad[i])
        );

        assign idle[i]  = (slot_state[i] == SLOT_IDLE);
        assign armed[i] = (slot_state[i] == SLOT_ARMED);
    end

    assign valid_rel = released_addr_onehot_i & armed;

    always_comb begin
        rel_cnt = '0;
        for (int i = 0; i < NumSlots; i++) begin
            rel_cnt = rel_cnt + {{IidW{1'b0}}, valid_rel[i]};
        end
        pending_d = pending_q + {{IidW{1'b0}}, accept} - rel_cnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_q | (|bad);
        end
    end

    assign release_en_o  = rel_en;
    assign num_pending_o = pending_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_simmem_rsp_release_timer.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run against an enabled-tick based reference model.
module tb_simmem_rsp_release_timer;

    localparam int NS = 16;
    localparam int DW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          entry_valid_i;
    logic          entry_ready_o;
    logic [IW-1:0] entry_iid_i;
    logic [DW-1:0] entry_delay_i;
    logic          count_en_i;
    logic [NS-1:0] release_en_o;
    logic [NS-1:0] released_addr_onehot_i;
    logic [IW:0]   num_pending_o;
    logic          err_o;

    simmem_rsp_release_timer #(
        .NumSlots (NS),
        .DelayW   (DW),
        .IidW     (IW)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .entry_valid_i          (entry_valid_i),
        .entry_ready_o          (entry_ready_o),
        .entry_iid_i            (entry_iid_i),
        .entry_delay_i          (entry_delay_i),
        .count_en_i             (count_en_i),
        .release_en_o           (release_en_o),
        .released_addr_onehot_i (released_addr_onehot_i),
        .num_pending_o          (num_pending_o),
        .err_o                  (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a slot is armed once the global count of enabled edges reaches
    // the target recorded at accept time.
    bit busy [NS];
    int target [NS];
    int en_ticks = 0;
    bit m_err = 0;

    typedef struct {
        logic          v;
        logic [IW-1:0] iid;
        logic [DW-1:0] d;
        logic          cen;
        logic [NS-1:0] rel;
        logic          rdy;
        logic [NS-1:0] exp_rel;
        logic [IW:0]   exp_pend;
        logic          exp_err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] m_rel_en();
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = busy[i] && (en_ticks >= target[i]);
        return r;
    endfunction

    function automatic logic [IW:0] m_pending();
        int n = 0;
        for (int i = 0; i < NS; i++) n += int'(busy[i]);
        return (IW+1)'(n);
    endfunction

    task automatic cycle(input logic v, input logic [IW-1:0] iid, input logic [DW-1:0] d,
                         input logic cen, input logic [NS-1:0] rel, output logic rdy_seen);
        bit acc;
        logic [NS-1:0] armed_pre;
        entry_valid_i          = v;
        entry_iid_i            = iid;
        entry_delay_i          = d;
        count_en_i             = cen;
        released_addr_onehot_i = rel;
        #1;
        rdy_seen = entry_ready_o;
        chk("ready", {31'b0, entry_ready_o}, {31'b0, !busy[iid]});
        acc       = v && !busy[iid];
        armed_pre = m_rel_en();
        @(posedge clk);
        for (int i = 0; i < NS; i++) begin
            if (rel[i] && !armed_pre[i]) m_err = 1;
            if (rel[i] && armed_pre[i]) busy[i] = 0;
        end
        if (cen) en_ticks++;
        if (acc) begin
            busy[iid]   = 1;
            target[iid] = en_ticks + ((d <= 1) ? 0 : int'(d) - 1);
        end
        #1;
        chk("release_en", {16'b0, release_en_o}, {16'b0, m_rel_en()});
        chk("num_pending", {27'b0, num_pending_o}, {27'b0, m_pending()});
        chk("err", {31'b0, err_o}, {31'b0, m_err});
    endtask

    task automatic idle_cycle(input logic cen);
        logic r;
        cycle(1'b0, '0, '0, cen, '0, r);
    endtask

    task automatic do_reset();
        entry_valid_i          = 1'b0;
        released_addr_onehot_i = '0;
        count_en_i             = 1'b0;
        rst_i                  = 1'b1;
        #1;
        chk("rst_async_release_en", {16'b0, release_en_o}, 32'h0);
        for (int i = 0; i < NS; i++) busy[i] = 0;
        m_err = 0;
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pending", {27'b0, num_pending_o}, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_release_en", {16'b0, release_en_o}, 32'h0);
    endtask

    initial begin
        logic r;
        logic [NS-1:0] rel;
        logic [DW-1:0] d;
        int sel;

        //          v   iid   d     cen  rel       rdy  exp_rel   pend  err
        tbl[0]  = '{1, 4'd3, 8'd5, 1, 16'h0000, 1, 16'h0000, 5'd1, 0};
        tbl[1]  = '{0, 4'd3, 8'd0, 1, 16'h0000, 0, 16'h0000, 5'd1, 0};
        tbl[2]  = '{0, 4'd3, 8'd0, 1, 16'h0000, 0, 16'h0000, 5'd1, 0};
        tbl[3]  = '{0, 4'd3, 8'd0, 1, 16'h0000, 0, 16'h0000, 5'd1, 0};
        tbl[4]  = '{0, 4'd3, 8'd0, 1, 16'h0000, 0, 16'h0008, 5'd1, 0};
        tbl[5]  = '{0, 4'd3, 8'd0, 1, 16'h0008, 0, 16'h0000, 5'd0, 0};
        tbl[6]  = '{0, 4'd3, 8'd0, 1, 16'h0000, 1, 16'h0000, 5'd0, 0};
        tbl[7]  = '{1, 4'd0, 8'd0, 1, 16'h0000, 1, 16'h0001, 5'd1, 0};
        tbl[8]  = '{0, 4'd0, 8'd0, 1, 16'h0001, 0, 16'h0000, 5'd0, 0};
        tbl[9]  = '{1, 4'd0, 8'd1, 1, 16'h0000, 1, 16'h0001, 5'd1, 0};
        tbl[10] = '{1, 4'd0, 8'd1, 1, 16'h0001, 0, 16'h0000, 5'd0, 0};
        tbl[11] = '{1, 4'd0, 8'd1, 1, 16'h0000, 1, 16'h0001, 5'd1, 0};
        tbl[12] = '{0, 4'd9, 8'd0, 1, 16'h0200, 1, 16'h0001, 5'd1, 1};
        tbl[13] = '{0, 4'd0, 8'd0, 1, 16'h0001, 0, 16'h0000, 5'd0, 1};
        tbl[14] = '{0, 4'd5, 8'd0, 1, 16'h0000, 1, 16'h0000, 5'd0, 1};

        entry_valid_i          = 1'b0;
        entry_iid_i            = '0;
        entry_delay_i          = '0;
        count_en_i             = 1'b0;
        released_addr_onehot_i = '0;
        rst_i                  = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        for (int k = 0; k < 15; k++) begin
            cycle(tbl[k].v, tbl[k].iid, tbl[k].d, tbl[k].cen, tbl[k].rel, r);
            chk($sformatf("tbl%0d_ready", k), {31'b0, r}, {31'b0, tbl[k].rdy});
            chk($sformatf("tbl%0d_release_en", k), {16'b0, release_en_o}, {16'b0, tbl[k].exp_rel});
            chk($sformatf("tbl%0d_pending", k), {27'b0, num_pending_o}, {27'b0, tbl[k].exp_pend});
            chk($sformatf("tbl%0d_err", k), {31'b0, err_o}, {31'b0, tbl[k].exp_err});
        end

        // D=4 on slot 2 with the countdown frozen for three cycles.
        do_reset();
        cycle(1'b1, 4'd2, 8'd4, 1'b1, '0, r);
        idle_cycle(1'b1);
        repeat (3) idle_cycle(1'b0);
        idle_cycle(1'b1);
        chk("pause_early", {31'b0, release_en_o[2]}, 32'h0);
        idle_cycle(1'b1);
        chk("pause_rise", {31'b0, release_en_o[2]}, 32'h1);
        cycle(1'b0, 4'd2, 8'd0, 1'b1, 16'h0004, r);
        chk("pause_freed", {27'b0, num_pending_o}, 32'h0);

        // Fill every slot with the maximum delay.
        for (int i = 0; i < NS; i++) cycle(1'b1, IW'(i), 8'd255, 1'b1, '0, r);
        chk("full_pending", {27'b0, num_pending_o}, 32'd16);
        for (int i = 0; i < NS; i++) begin
            cycle(1'b1, IW'(i), 8'd3, 1'b1, '0, r);
            chk("full_ready", {31'b0, r}, 32'h0);
        end
        chk("full_pending_hold", {27'b0, num_pending_o}, 32'd16);
        repeat (245) idle_cycle(1'b1);
        chk("full_armed", {16'b0, release_en_o}, 32'h0000ffff);
        cycle(1'b1, 4'd7, 8'd255, 1'b1, 16'h0080, r);
        chk("same_cycle_ready", {31'b0, r}, 32'h0);
        chk("same_cycle_pending", {27'b0, num_pending_o}, 32'd15);
        cycle(1'b1, 4'd7, 8'd255, 1'b1, '0, r);
        chk("next_cycle_ready", {31'b0, r}, 32'h1);
        chk("next_cycle_pending", {27'b0, num_pending_o}, 32'd16);
        chk("full_err_clear", {31'b0, err_o}, 32'h0);

        // Reset while fifteen slots are armed.
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      d = DW'($urandom_range(0, 1));
            else if (sel == 7) d = DW'($urandom_range(20, 60));
            else               d = DW'($urandom_range(2, 10));
            rel = m_rel_en() & NS'($urandom) & NS'($urandom);
            if ($urandom_range(0, 199) == 0) rel[$urandom_range(0, NS-1)] = 1'b1;
            cycle(1'($urandom), IW'($urandom), d, ($urandom_range(0, 4) != 0), rel, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
